// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word type, RAM handshake state and arbiter FSM encoding.
package cpu_types_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE,
    DREQ,
    IREQ,
    DRESP,
    IRESP
  } arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of datapath request/response and RAM port signals around the arbiter.
interface mem_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) ();
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              ihit;
  logic [WORD_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dhit;
  logic [WORD_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;
  logic              fault;

  // slave: the arbiter itself
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, fault
  );

  // master: the request unit plus the RAM
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, fault
  );
endinterface

// File: rtl/arb_watchdog.sv
// Saturating stall counter; flags the cycle in which the count reaches TIMEOUT.
module arb_watchdog #(
  parameter int TIMEOUT = 64,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic CLK,
  input  logic nRST,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                r_cnt <= '0;
    else if (i_clr)                           r_cnt <= '0;
    else if (i_en && r_cnt != CW'(TIMEOUT))   r_cnt <= r_cnt + CW'(1);
  end

  // Fires combinationally on the stall cycle that brings the count to TIMEOUT.
  assign o_expired = i_en && (r_cnt >= CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_arbiter.sv
// Serialises data/instruction requests onto one RAM port, data first, grant held to completion.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int WORD_W  = 32
) (
  input logic           CLK,
  input logic           nRST,
  mem_arbiter_if.slave  bus
);
  arb_state_t        r_state;
  logic              r_ihit;
  logic              r_dhit;
  logic              r_fault;
  logic [WORD_W-1:0] r_iload;
  logic [WORD_W-1:0] r_dload;

  logic              w_in_req;
  logic              w_expired;
  logic              w_fail;
  logic              w_dreq;
  logic              w_ramREN;
  logic              w_ramWEN;
  logic [WORD_W-1:0] w_ramaddr;
  logic [WORD_W-1:0] w_ramstore;

  assign w_dreq   = bus.dREN | bus.dWEN;
  assign w_in_req = (r_state == DREQ) || (r_state == IREQ);
  assign w_fail   = (bus.ramstate == ERROR) || w_expired;

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .CLK       (CLK),
    .nRST      (nRST),
    .i_clr     (!w_in_req),
    .i_en      (w_in_req && (bus.ramstate != ACCESS)),
    .o_expired (w_expired)
  );

  // Enables come straight from state and live request so reset or a dropped request cuts them at once.
  always_comb begin
    w_ramREN   = 1'b0;
    w_ramWEN   = 1'b0;
    w_ramaddr  = bus.iaddr;
    w_ramstore = bus.dstore;
    case (r_state)
      DREQ: begin
        w_ramREN  = bus.dREN;
        w_ramWEN  = bus.dWEN;
        w_ramaddr = bus.daddr;
      end
      IREQ:    w_ramREN = bus.iREN;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_ihit  <= 1'b0;
      r_dhit  <= 1'b0;
      r_fault <= 1'b0;
      r_iload <= '0;
      r_dload <= '0;
    end else begin
      r_ihit <= 1'b0;
      r_dhit <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_dreq)        r_state <= DREQ;
          else if (bus.iREN) r_state <= IREQ;
        end
        DREQ: begin
          if (w_fail) begin
            r_fault <= 1'b1;
            r_state <= IDLE;
          end else if (!w_dreq) begin
            r_state <= IDLE;
          end else if (bus.ramstate == ACCESS) begin
            if (bus.dREN) r_dload <= bus.ramload;
            r_dhit  <= 1'b1;
            r_state <= DRESP;
          end
        end
        // Grant is locked: a data request raised here waits for IRESP to finish.
        IREQ: begin
          if (w_fail) begin
            r_fault <= 1'b1;
            r_state <= IDLE;
          end else if (!bus.iREN) begin
            r_state <= IDLE;
          end else if (bus.ramstate == ACCESS) begin
            r_iload <= bus.ramload;
            r_ihit  <= 1'b1;
            r_state <= IRESP;
          end
        end
        DRESP:   r_state <= IDLE;
        IRESP:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ihit     = r_ihit;
  assign bus.dhit     = r_dhit;
  assign bus.iload    = r_iload;
  assign bus.dload    = r_dload;
  assign bus.fault    = r_fault;
  assign bus.ramREN   = w_ramREN;
  assign bus.ramWEN   = w_ramWEN;
  assign bus.ramaddr  = w_ramaddr;
  assign bus.ramstore = w_ramstore;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of mem_arbiter: reset, fetch, priority, grant lock, ERROR and timeout faults.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   n_chk;
  int   n_fail;

  mem_arbiter_if #(.WORD_W(32)) bus ();

  mem_arbiter #(.TIMEOUT(4), .WORD_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    nRST = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = BUSY;

    // Reset held with a pending fetch and a stalled RAM
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ihit",   {31'd0, bus.ihit},   32'd0);
      chk("rst_dhit",   {31'd0, bus.dhit},   32'd0);
      chk("rst_fault",  {31'd0, bus.fault},  32'd0);
      chk("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
      chk("rst_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
    end
    chk("rst_iload", bus.iload, 32'd0);
    chk("rst_dload", bus.dload, 32'd0);
    bus.iREN = 1'b0;
    bus.ramstate = FREE;
    nRST = 1'b1;
    tick();

    // Instruction fetch, 2 BUSY then ACCESS
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0040; bus.ramstate = BUSY;
    settle();
    chk("if_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("if_idle_addr",   bus.ramaddr,         32'h40);
    tick();
    chk("if_req_ramREN",  {31'd0, bus.ramREN}, 32'd1);
    chk("if_req_ramWEN",  {31'd0, bus.ramWEN}, 32'd0);
    chk("if_req_addr",    bus.ramaddr,         32'h40);
    tick();
    chk("if_busy2_ramREN", {31'd0, bus.ramREN}, 32'd1);
    chk("if_busy2_ihit",   {31'd0, bus.ihit},   32'd0);
    bus.ramstate = ACCESS; bus.ramload = 32'h2401_0005;
    tick();
    chk("if_ihit",       {31'd0, bus.ihit},   32'd1);
    chk("if_iload",      bus.iload,           32'h2401_0005);
    chk("if_resp_ramREN",{31'd0, bus.ramREN}, 32'd0);
    bus.iREN = 1'b0; bus.ramstate = FREE;
    tick();
    chk("if_ihit_pulse", {31'd0, bus.ihit},   32'd0);

    // Simultaneous iREN and dWEN: data wins
    bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dWEN = 1'b1;
    bus.daddr = 32'h80; bus.dstore = 32'hDEAD_BEEF; bus.ramstate = BUSY;
    tick();
    chk("pr_ramWEN",   {31'd0, bus.ramWEN}, 32'd1);
    chk("pr_ramREN",   {31'd0, bus.ramREN}, 32'd0);
    chk("pr_ramaddr",  bus.ramaddr,         32'h80);
    chk("pr_ramstore", bus.ramstore,        32'hDEAD_BEEF);
    bus.ramstate = ACCESS;
    tick();
    chk("pr_dhit",     {31'd0, bus.dhit},   32'd1);
    chk("pr_no_ihit",  {31'd0, bus.ihit},   32'd0);
    chk("pr_dload_wr", bus.dload,           32'd0);
    bus.dWEN = 1'b0; bus.ramstate = BUSY;
    tick();
    chk("pr_idle_ihit", {31'd0, bus.ihit},  32'd0);
    tick();
    chk("pr_ireq_REN",  {31'd0, bus.ramREN}, 32'd1);
    chk("pr_ireq_addr", bus.ramaddr,         32'h44);
    bus.ramstate = ACCESS; bus.ramload = 32'h1111_2222;
    tick();
    chk("pr_ihit_3cyc", {31'd0, bus.ihit},  32'd1);
    chk("pr_iload",     bus.iload,          32'h1111_2222);
    bus.iREN = 1'b0; bus.ramstate = FREE;
    tick();

    // Grant lock: dREN raised during IREQ waits
    bus.iREN = 1'b1; bus.iaddr = 32'h48; bus.ramstate = BUSY;
    tick();
    bus.dREN = 1'b1; bus.daddr = 32'h90;
    settle();
    chk("lk_REN",  {31'd0, bus.ramREN}, 32'd1);
    chk("lk_addr", bus.ramaddr,         32'h48);
    chk("lk_WEN",  {31'd0, bus.ramWEN}, 32'd0);
    tick();
    chk("lk_addr2", bus.ramaddr,        32'h48);
    chk("lk_dhit0", {31'd0, bus.dhit},  32'd0);
    bus.ramstate = ACCESS; bus.ramload = 32'hAAAA_0001;
    tick();
    chk("lk_ihit",  {31'd0, bus.ihit},  32'd1);
    chk("lk_resp_REN", {31'd0, bus.ramREN}, 32'd0);
    bus.iREN = 1'b0; bus.ramstate = BUSY;
    tick();
    chk("lk_idle_REN", {31'd0, bus.ramREN}, 32'd0);
    tick();
    chk("lk_dreq_REN",  {31'd0, bus.ramREN}, 32'd1);
    chk("lk_dreq_addr", bus.ramaddr,         32'h90);
    bus.ramstate = ACCESS; bus.ramload = 32'h55AA_55AA;
    tick();
    chk("lk_dhit",  {31'd0, bus.dhit}, 32'd1);
    chk("lk_dload", bus.dload,         32'h55AA_55AA);
    bus.dREN = 1'b0; bus.ramstate = FREE;
    tick();

    // ERROR during DREQ
    bus.dREN = 1'b1; bus.daddr = 32'hA0; bus.ramstate = BUSY;
    tick();
    bus.ramstate = ERROR; bus.ramload = 32'h0F0F_0F0F;
    settle();
    chk("er_fault_pre", {31'd0, bus.fault}, 32'd0);
    tick();
    chk("er_fault",  {31'd0, bus.fault},  32'd1);
    chk("er_dhit",   {31'd0, bus.dhit},   32'd0);
    chk("er_dload",  bus.dload,           32'h55AA_55AA);
    chk("er_idle",   {31'd0, bus.ramREN}, 32'd0);
    bus.dREN = 1'b0; bus.ramstate = FREE;
    tick();

    // Reset clears the sticky fault
    nRST = 1'b0;
    settle();
    chk("rst2_fault", {31'd0, bus.fault}, 32'd0);
    chk("rst2_dload", bus.dload,          32'd0);
    tick();
    nRST = 1'b1;
    tick();

    // Timeout: 4 BUSY cycles in DREQ
    bus.dREN = 1'b1; bus.daddr = 32'hB0; bus.ramstate = BUSY;
    tick();
    chk("to_enter_REN", {31'd0, bus.ramREN}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("to_fault",  {31'd0, bus.fault},  (i == 4) ? 32'd1 : 32'd0);
      chk("to_ramREN", {31'd0, bus.ramREN}, (i == 4) ? 32'd0 : 32'd1);
      chk("to_dhit",   {31'd0, bus.dhit},   32'd0);
    end
    bus.dREN = 1'b0; bus.ramstate = FREE;
    tick();

    // Fault sticks across a later good read
    bus.dREN = 1'b1; bus.daddr = 32'hC0; bus.ramstate = ACCESS; bus.ramload = 32'h0BAD_F00D;
    tick();
    tick();
    chk("st_dhit",  {31'd0, bus.dhit},  32'd1);
    chk("st_dload", bus.dload,          32'h0BAD_F00D);
    chk("st_fault", {31'd0, bus.fault}, 32'd1);
    bus.dREN = 1'b0; bus.ramstate = FREE;
    tick();
    chk("st_fault2", {31'd0, bus.fault}, 32'd1);
    nRST = 1'b0;
    settle();
    chk("st_fault_rst", {31'd0, bus.fault}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
